// File: rtl/spmv_cfg_pkg.sv
// SpMV config-slot programming: shared state, status and register map.
// Imported by the config master and the config register block.
package spmv_cfg_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_WR_REQ  = 3'd1,
    ST_WR_RESP = 3'd2,
    ST_RD_REQ  = 3'd3,
    ST_RD_RESP = 3'd4,
    ST_DONE    = 3'd5,
    ST_HALT    = 3'd6
  } state_e;

  localparam logic [2:0] STS_OK       = 3'd0;
  localparam logic [2:0] STS_WR_ERR   = 3'd1;
  localparam logic [2:0] STS_RD_ERR   = 3'd2;
  localparam logic [2:0] STS_MISMATCH = 3'd3;
  localparam logic [2:0] STS_TIMEOUT  = 3'd4;
  localparam logic [2:0] STS_BAD_IDX  = 3'd5;

  localparam int          CFG_NUM_KERNEL     = 4;
  localparam int          CFG_PER_ADDR_SPACE = 12;
  localparam logic [31:0] CFG_CTRL_OFFSET    = 32'h00;
  localparam logic [31:0] CFG_ROW_OFFSET     = 32'h04;
  localparam logic [31:0] CFG_NNZ_OFFSET     = 32'h08;

  // ctrl goes last so the kernel never sees a half-programmed slot
  function automatic logic [31:0] beat_offset(
    input logic [1:0]  beat,
    input logic [31:0] row_off,
    input logic [31:0] nnz_off,
    input logic [31:0] ctrl_off
  );
    case (beat)
      2'd0:    beat_offset = row_off;
      2'd1:    beat_offset = nnz_off;
      default: beat_offset = ctrl_off;
    endcase
  endfunction

endpackage

// File: rtl/spmv_config_master.sv
// AXI4-Lite initiator that programs one SpMV kernel config slot
// (row_num, nnz_num, then ctrl) with optional ctrl readback.
module spmv_config_master
  import spmv_cfg_pkg::*;
#(
  parameter int          CONF_NUM_KERNEL = CFG_NUM_KERNEL,
  parameter logic [31:0] BASE_ADDR       = 32'h0,
  parameter int          PER_ADDR_SPACE  = CFG_PER_ADDR_SPACE,
  parameter logic [31:0] CTRL_OFFSET     = CFG_CTRL_OFFSET,
  parameter logic [31:0] ROW_OFFSET      = CFG_ROW_OFFSET,
  parameter logic [31:0] NNZ_OFFSET      = CFG_NNZ_OFFSET,
  parameter int          TIMEOUT_CYCLES  = 1024,
  parameter int          KIDX_W          = $clog2(CONF_NUM_KERNEL) + 1
) (
  input  logic              aclk,
  input  logic              areset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [KIDX_W-1:0] cmd_kidx,
  input  logic [31:0]       cmd_ctrl,
  input  logic [31:0]       cmd_row,
  input  logic [31:0]       cmd_nnz,
  input  logic              cmd_verify,
  output logic              done,
  output logic [2:0]        status,
  output logic              halted,
  output logic              m_axil_awvalid,
  output logic [31:0]       m_axil_awaddr,
  input  logic              m_axil_awready,
  output logic              m_axil_wvalid,
  output logic [31:0]       m_axil_wdata,
  input  logic              m_axil_wready,
  input  logic              m_axil_bvalid,
  input  logic [1:0]        m_axil_bresp,
  output logic              m_axil_bready,
  output logic              m_axil_arvalid,
  output logic [31:0]       m_axil_araddr,
  input  logic              m_axil_arready,
  input  logic              m_axil_rvalid,
  input  logic [31:0]       m_axil_rdata,
  input  logic [1:0]        m_axil_rresp,
  output logic              m_axil_rready
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_CYCLES - 1);

  state_e      state;
  logic [31:0] ctrl_q;
  logic [31:0] row_q;
  logic [31:0] nnz_q;
  logic [31:0] slot_q;
  logic        verify_q;
  logic [1:0]  beat;
  logic        aw_done;
  logic        w_done;
  logic        to_halt;
  logic [TW-1:0] tcnt;

  logic [31:0] slot_cmd;
  logic        bad_idx;
  logic        accept;
  logic        aw_hs;
  logic        w_hs;
  logic        b_hs;
  logic        ar_hs;
  logic        r_hs;
  logic        wr_both;
  logic        in_phase;
  logic        advance;
  logic        expired;

  assign slot_cmd = BASE_ADDR
                  + 32'(cmd_kidx) * 32'(PER_ADDR_SPACE);
  assign bad_idx  = 32'(cmd_kidx) >= 32'(CONF_NUM_KERNEL);

  // gated by areset so cmd_ready falls with the reset, not the next edge
  assign cmd_ready = ~areset & (state == ST_IDLE);
  assign accept    = cmd_valid & cmd_ready;

  assign aw_hs   = m_axil_awvalid & m_axil_awready;
  assign w_hs    = m_axil_wvalid & m_axil_wready;
  assign b_hs    = m_axil_bvalid & m_axil_bready;
  assign ar_hs   = m_axil_arvalid & m_axil_arready;
  assign r_hs    = m_axil_rvalid & m_axil_rready;
  assign wr_both = (aw_done | aw_hs) & (w_done | w_hs);

  always_comb begin
    in_phase = 1'b1;
    advance  = 1'b0;
    case (state)
      ST_WR_REQ:  advance = wr_both;
      ST_WR_RESP: advance = b_hs;
      ST_RD_REQ:  advance = ar_hs;
      ST_RD_RESP: advance = r_hs;
      default:    in_phase = 1'b0;
    endcase
  end

  assign expired = in_phase & ~advance & (tcnt == T_LAST);

  // any state change clears the counter, so each phase gets a full budget
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      tcnt <= '0;
    end else if (in_phase & ~advance & ~expired) begin
      tcnt <= tcnt + TW'(1);
    end else begin
      tcnt <= '0;
    end
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      state          <= ST_IDLE;
      ctrl_q         <= '0;
      row_q          <= '0;
      nnz_q          <= '0;
      slot_q         <= '0;
      verify_q       <= 1'b0;
      beat           <= '0;
      aw_done        <= 1'b0;
      w_done         <= 1'b0;
      to_halt        <= 1'b0;
      done           <= 1'b0;
      status         <= '0;
      halted         <= 1'b0;
      m_axil_awvalid <= 1'b0;
      m_axil_awaddr  <= '0;
      m_axil_wvalid  <= 1'b0;
      m_axil_wdata   <= '0;
      m_axil_bready  <= 1'b0;
      m_axil_arvalid <= 1'b0;
      m_axil_araddr  <= '0;
      m_axil_rready  <= 1'b0;
    end else begin
      done <= 1'b0;
      if (expired) begin
        m_axil_awvalid <= 1'b0;
        m_axil_wvalid  <= 1'b0;
        m_axil_bready  <= 1'b0;
        m_axil_arvalid <= 1'b0;
        m_axil_rready  <= 1'b0;
        status         <= STS_TIMEOUT;
        done           <= 1'b1;
        to_halt        <= 1'b1;
        state          <= ST_DONE;
      end else begin
        case (state)
          ST_IDLE: begin
            if (accept) begin
              ctrl_q   <= cmd_ctrl;
              row_q    <= cmd_row;
              nnz_q    <= cmd_nnz;
              verify_q <= cmd_verify;
              slot_q   <= slot_cmd;
              if (bad_idx) begin
                status <= STS_BAD_IDX;
                done   <= 1'b1;
                state  <= ST_DONE;
              end else begin
                beat           <= 2'd0;
                m_axil_awvalid <= 1'b1;
                m_axil_wvalid  <= 1'b1;
                m_axil_awaddr  <= slot_cmd + ROW_OFFSET;
                m_axil_wdata   <= cmd_row;
                aw_done        <= 1'b0;
                w_done         <= 1'b0;
                state          <= ST_WR_REQ;
              end
            end
          end
          ST_WR_REQ: begin
            if (aw_hs) begin
              m_axil_awvalid <= 1'b0;
              aw_done        <= 1'b1;
            end
            if (w_hs) begin
              m_axil_wvalid <= 1'b0;
              w_done        <= 1'b1;
            end
            if (wr_both) begin
              m_axil_bready <= 1'b1;
              state         <= ST_WR_RESP;
            end
          end
          ST_WR_RESP: begin
            if (b_hs) begin
              m_axil_bready <= 1'b0;
              if (m_axil_bresp != 2'b00) begin
                status <= STS_WR_ERR;
                done   <= 1'b1;
                state  <= ST_DONE;
              end else if (beat != 2'd2) begin
                beat           <= beat + 2'd1;
                m_axil_awvalid <= 1'b1;
                m_axil_wvalid  <= 1'b1;
                m_axil_awaddr  <= slot_q + beat_offset(
                  beat + 2'd1, ROW_OFFSET, NNZ_OFFSET, CTRL_OFFSET);
                m_axil_wdata   <= (beat == 2'd0) ? nnz_q : ctrl_q;
                aw_done        <= 1'b0;
                w_done         <= 1'b0;
                state          <= ST_WR_REQ;
              end else if (verify_q) begin
                m_axil_arvalid <= 1'b1;
                m_axil_araddr  <= slot_q + CTRL_OFFSET;
                state          <= ST_RD_REQ;
              end else begin
                status <= STS_OK;
                done   <= 1'b1;
                state  <= ST_DONE;
              end
            end
          end
          ST_RD_REQ: begin
            if (ar_hs) begin
              m_axil_arvalid <= 1'b0;
              m_axil_rready  <= 1'b1;
              state          <= ST_RD_RESP;
            end
          end
          ST_RD_RESP: begin
            if (r_hs) begin
              m_axil_rready <= 1'b0;
              done          <= 1'b1;
              state         <= ST_DONE;
              if (m_axil_rresp != 2'b00) begin
                status <= STS_RD_ERR;
              end else if (m_axil_rdata != ctrl_q) begin
                status <= STS_MISMATCH;
              end else begin
                status <= STS_OK;
              end
            end
          end
          ST_DONE: begin
            halted <= to_halt;
            state  <= to_halt ? ST_HALT : ST_IDLE;
          end
          ST_HALT: begin
            halted <= 1'b1;
          end
          default: begin
            state <= ST_IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_spmv_config_master.sv
// Directed bench for spmv_config_master with a delay-configurable
// AXI4-Lite slave model and a table of command vectors.
module tb_spmv_config_master;

  localparam int NK    = 4;
  localparam int TO    = 1024;
  localparam int NEVER = 1000000;
  localparam int NV    = 10;

  logic        aclk = 1'b0;
  logic        areset = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [2:0]  cmd_kidx = '0;
  logic [31:0] cmd_ctrl = '0;
  logic [31:0] cmd_row = '0;
  logic [31:0] cmd_nnz = '0;
  logic        cmd_verify = 1'b0;
  logic        done;
  logic [2:0]  status;
  logic        halted;
  logic        m_axil_awvalid;
  logic [31:0] m_axil_awaddr;
  logic        m_axil_awready = 1'b0;
  logic        m_axil_wvalid;
  logic [31:0] m_axil_wdata;
  logic        m_axil_wready = 1'b0;
  logic        m_axil_bvalid = 1'b0;
  logic [1:0]  m_axil_bresp = '0;
  logic        m_axil_bready;
  logic        m_axil_arvalid;
  logic [31:0] m_axil_araddr;
  logic        m_axil_arready = 1'b0;
  logic        m_axil_rvalid = 1'b0;
  logic [31:0] m_axil_rdata = '0;
  logic [1:0]  m_axil_rresp = '0;
  logic        m_axil_rready;

  always #5 aclk = ~aclk;

  spmv_config_master #(
    .CONF_NUM_KERNEL(NK),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .aclk(aclk),
    .areset(areset),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_kidx(cmd_kidx),
    .cmd_ctrl(cmd_ctrl),
    .cmd_row(cmd_row),
    .cmd_nnz(cmd_nnz),
    .cmd_verify(cmd_verify),
    .done(done),
    .status(status),
    .halted(halted),
    .m_axil_awvalid(m_axil_awvalid),
    .m_axil_awaddr(m_axil_awaddr),
    .m_axil_awready(m_axil_awready),
    .m_axil_wvalid(m_axil_wvalid),
    .m_axil_wdata(m_axil_wdata),
    .m_axil_wready(m_axil_wready),
    .m_axil_bvalid(m_axil_bvalid),
    .m_axil_bresp(m_axil_bresp),
    .m_axil_bready(m_axil_bready),
    .m_axil_arvalid(m_axil_arvalid),
    .m_axil_araddr(m_axil_araddr),
    .m_axil_arready(m_axil_arready),
    .m_axil_rvalid(m_axil_rvalid),
    .m_axil_rdata(m_axil_rdata),
    .m_axil_rresp(m_axil_rresp),
    .m_axil_rready(m_axil_rready)
  );

  logic [106:0] all_out;
  assign all_out = {cmd_ready, done, status, halted,
                    m_axil_awvalid, m_axil_awaddr,
                    m_axil_wvalid, m_axil_wdata, m_axil_bready,
                    m_axil_arvalid, m_axil_araddr, m_axil_rready};

  // slave configuration, written only by the stimulus process
  int          aw_lag = 0;
  int          w_lag = 0;
  int          b_lag = 0;
  int          ar_lag = 0;
  int          r_lag = 0;
  int          err_idx = -1;
  logic [1:0]  err_resp = '0;
  logic [31:0] rd_data = '0;
  logic [1:0]  rd_resp = '0;

  // slave state, written only by the slave process
  logic [31:0] aw_q[$];
  logic [31:0] w_q[$];
  logic [31:0] ar_q[$];
  int aw_n = 0, w_n = 0, b_n = 0, ar_n = 0, r_n = 0;
  int aw_wait = 0, w_wait = 0, b_wait = 0, ar_wait = 0, r_wait = 0;
  int b_lim = 0;
  logic b_commit = 1'b0, r_commit = 1'b0;
  logic aw_seen = 1'b0, w_seen = 1'b0, ar_seen = 1'b0;
  logic [31:0] aw_first = '0, w_first = '0, ar_first = '0;
  int overlap = 0;
  int unstable = 0;

  always @(negedge aclk) begin
    if (areset) begin
      m_axil_awready = 1'b0;
      m_axil_wready  = 1'b0;
      m_axil_bvalid  = 1'b0;
      m_axil_arready = 1'b0;
      m_axil_rvalid  = 1'b0;
      b_commit = 1'b0;
      r_commit = 1'b0;
      aw_seen = 1'b0;
      w_seen = 1'b0;
      ar_seen = 1'b0;
      aw_wait = 0; w_wait = 0; b_wait = 0;
      ar_wait = 0; r_wait = 0;
      if (aw_n > w_n) w_n = aw_n;
      else aw_n = w_n;
      b_n = aw_n;
      r_n = ar_n;
    end else begin
      if (m_axil_arvalid && (m_axil_awvalid || m_axil_wvalid))
        overlap++;
      // AW
      if (m_axil_awready) m_axil_awready = 1'b0;
      else if (m_axil_awvalid) begin
        if (!aw_seen) begin aw_seen = 1'b1; aw_first = m_axil_awaddr; end
        else if (m_axil_awaddr != aw_first) unstable++;
        if (aw_wait >= aw_lag) begin
          m_axil_awready = 1'b1;
          aw_q.push_back(m_axil_awaddr);
          aw_n++; aw_seen = 1'b0; aw_wait = 0;
        end else aw_wait++;
      end
      // W
      if (m_axil_wready) m_axil_wready = 1'b0;
      else if (m_axil_wvalid) begin
        if (!w_seen) begin w_seen = 1'b1; w_first = m_axil_wdata; end
        else if (m_axil_wdata != w_first) unstable++;
        if (w_wait >= w_lag) begin
          m_axil_wready = 1'b1;
          w_q.push_back(m_axil_wdata);
          w_n++; w_seen = 1'b0; w_wait = 0;
        end else w_wait++;
      end
      // B
      if (b_commit) begin
        m_axil_bvalid = 1'b0; b_commit = 1'b0; b_n++;
      end else begin
        if (!m_axil_bvalid && aw_n > b_n && w_n > b_n) begin
          if (b_wait == 0)
            b_lim = (b_lag < 0) ? int'($urandom_range(0, 4)) : b_lag;
          if (b_wait >= b_lim) begin
            m_axil_bvalid = 1'b1;
            m_axil_bresp = (b_n == err_idx) ? err_resp : 2'b00;
            b_wait = 0;
          end else b_wait++;
        end
        if (m_axil_bvalid && m_axil_bready) b_commit = 1'b1;
      end
      // AR
      if (m_axil_arready) m_axil_arready = 1'b0;
      else if (m_axil_arvalid) begin
        if (!ar_seen) begin ar_seen = 1'b1; ar_first = m_axil_araddr; end
        else if (m_axil_araddr != ar_first) unstable++;
        if (ar_wait >= ar_lag) begin
          m_axil_arready = 1'b1;
          ar_q.push_back(m_axil_araddr);
          ar_n++; ar_seen = 1'b0; ar_wait = 0;
        end else ar_wait++;
      end
      // R
      if (r_commit) begin
        m_axil_rvalid = 1'b0; r_commit = 1'b0; r_n++;
      end else begin
        if (!m_axil_rvalid && ar_n > r_n) begin
          if (r_wait >= r_lag) begin
            m_axil_rvalid = 1'b1;
            m_axil_rdata = rd_data;
            m_axil_rresp = rd_resp;
            r_wait = 0;
          end else r_wait++;
        end
        if (m_axil_rvalid && m_axil_rready) r_commit = 1'b1;
      end
    end
  end

  typedef struct {
    logic [2:0]  kidx;
    logic [31:0] ctrl;
    logic [31:0] row;
    logic [31:0] nnz;
    logic        verify;
    int          err_beat;
    logic [1:0]  err_resp;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    int          aw_lag;
    int          w_lag;
    int          b_lag;
    int          ar_lag;
    int          r_lag;
    logic [2:0]  exp_status;
    int          exp_wr;
    int          exp_rd;
  } vec_t;

  vec_t vt [NV];

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] exp_addr(input logic [2:0] k,
                                           input int j);
    logic [31:0] off;
    off = (j == 0) ? 32'h4 : (j == 1) ? 32'h8 : 32'h0;
    return 32'd12 * 32'(k) + off;
  endfunction

  function automatic logic [31:0] exp_data(input vec_t v, input int j);
    return (j == 0) ? v.row : (j == 1) ? v.nnz : v.ctrl;
  endfunction

  task automatic configure(input vec_t v);
    aw_lag   = v.aw_lag;
    w_lag    = v.w_lag;
    b_lag    = v.b_lag;
    ar_lag   = v.ar_lag;
    r_lag    = v.r_lag;
    err_resp = v.err_resp;
    rd_data  = v.rdata;
    rd_resp  = v.rresp;
    err_idx  = (v.err_beat < 0) ? -1 : b_n + v.err_beat;
  endtask

  task automatic send(input vec_t v, output logic [2:0] st,
                      output int lat);
    @(negedge aclk);
    chk("cmd_ready_before_cmd", 32'(cmd_ready), 32'd1);
    cmd_valid  = 1'b1;
    cmd_kidx   = v.kidx;
    cmd_ctrl   = v.ctrl;
    cmd_row    = v.row;
    cmd_nnz    = v.nnz;
    cmd_verify = v.verify;
    @(negedge aclk);
    cmd_valid = 1'b0;
    lat = 1;
    while (!done && lat < 3000) begin
      @(negedge aclk);
      lat++;
    end
    st = status;
  endtask

  task automatic run_vec(input int i);
    vec_t v;
    logic [2:0] st;
    int lat, awb, wb, arb, nwr, nw, nrd;
    v = vt[i];
    configure(v);
    awb = aw_q.size();
    wb  = w_q.size();
    arb = ar_q.size();
    send(v, st, lat);
    chk($sformatf("v%0d_done", i), 32'(done), 32'd1);
    chk($sformatf("v%0d_status", i), 32'(st), 32'(v.exp_status));
    nwr = aw_q.size() - awb;
    nw  = w_q.size() - wb;
    nrd = ar_q.size() - arb;
    chk($sformatf("v%0d_aw_count", i), 32'(nwr), 32'(v.exp_wr));
    chk($sformatf("v%0d_w_count", i), 32'(nw), 32'(v.exp_wr));
    for (int j = 0; j < v.exp_wr && j < nwr && j < nw; j++) begin
      chk($sformatf("v%0d_awaddr%0d", i, j), aw_q[awb + j],
          exp_addr(v.kidx, j));
      chk($sformatf("v%0d_wdata%0d", i, j), w_q[wb + j],
          exp_data(v, j));
    end
    chk($sformatf("v%0d_ar_count", i), 32'(nrd), 32'(v.exp_rd));
    if (nrd > 0 && v.exp_rd > 0)
      chk($sformatf("v%0d_araddr", i), ar_q[arb],
          32'd12 * 32'(v.kidx));
    if (v.exp_status == 3'd5)
      chk($sformatf("v%0d_bad_idx_latency", i), 32'(lat), 32'd1);
    @(negedge aclk);
    chk($sformatf("v%0d_done_one_cycle", i), 32'(done), 32'd0);
    chk($sformatf("v%0d_ready_after", i), 32'(cmd_ready), 32'd1);
  endtask

  initial begin
    vec_t tv;
    logic [2:0] st;
    int lat, n;

    //        kidx  ctrl           row      nnz       vfy ebeat eresp rdata          rresp aw w  b  ar r  st  wr rd
    vt[0] = '{3'd2, 32'd1,         32'd100, 32'd5000, 1'b1, -1, 2'b00, 32'd1,         2'b00, 0, 0, 0, 0, 0, 3'd0, 3, 1};
    vt[1] = '{3'd1, 32'h55,        32'd7,   32'd9,    1'b0, -1, 2'b00, 32'd0,         2'b00, 3, 0, -1, 0, 0, 3'd0, 3, 0};
    vt[2] = '{3'd3, 32'd8,         32'd1,   32'd2,    1'b1,  1, 2'b10, 32'd8,         2'b00, 0, 0, 1, 0, 0, 3'd1, 2, 0};
    vt[3] = '{3'd0, 32'd7,         32'd3,   32'd4,    1'b1, -1, 2'b00, 32'hdeadbeef,  2'b00, 0, 0, 0, 0, 0, 3'd3, 3, 1};
    vt[4] = '{3'd0, 32'd7,         32'd3,   32'd4,    1'b1, -1, 2'b00, 32'd7,         2'b10, 0, 0, 0, 0, 0, 3'd2, 3, 1};
    vt[5] = '{3'd4, 32'd1,         32'd1,   32'd1,    1'b1, -1, 2'b00, 32'd0,         2'b00, 0, 0, 0, 0, 0, 3'd5, 0, 0};
    vt[6] = '{3'd7, 32'd1,         32'd1,   32'd1,    1'b0, -1, 2'b00, 32'd0,         2'b00, 0, 0, 0, 0, 0, 3'd5, 0, 0};
    vt[7] = '{3'd3, 32'hcafe0001,  32'hff,  32'h1234, 1'b1, -1, 2'b00, 32'hcafe0001,  2'b00, 0, 4, 5, 2, 3, 3'd0, 3, 1};
    vt[8] = '{3'd1, 32'd2,         32'd5,   32'd6,    1'b1,  0, 2'b11, 32'd2,         2'b00, 1, 1, 0, 0, 0, 3'd1, 1, 0};
    vt[9] = '{3'd2, 32'd9,         32'd8,   32'd7,    1'b1,  2, 2'b01, 32'd9,         2'b00, 0, 2, 0, 0, 0, 3'd1, 3, 0};

    #3;
    chk("reset_outputs_zero", 32'(|all_out), 32'd0);
    repeat (3) @(negedge aclk);
    #2 areset = 1'b0;
    #1;
    chk("reset_cmd_ready", 32'(cmd_ready), 32'd1);
    chk("reset_halted", 32'(halted), 32'd0);
    chk("reset_done", 32'(done), 32'd0);

    for (int i = 0; i < NV; i++) run_vec(i);

    // phase timeout: awready never rises
    tv = vt[1];
    tv.aw_lag = NEVER;
    tv.b_lag  = 0;
    configure(tv);
    send(tv, st, lat);
    chk("to_done", 32'(done), 32'd1);
    chk("to_status", 32'(st), 32'd4);
    chk("to_latency", 32'(lat), 32'(TO + 1));
    chk("to_awvalid_dropped", 32'(m_axil_awvalid), 32'd0);
    chk("to_wvalid_dropped", 32'(m_axil_wvalid), 32'd0);
    @(negedge aclk);
    chk("to_halted", 32'(halted), 32'd1);
    chk("to_halt_not_ready", 32'(cmd_ready), 32'd0);
    chk("to_done_pulse", 32'(done), 32'd0);
    cmd_valid = 1'b1;
    repeat (5) @(negedge aclk);
    cmd_valid = 1'b0;
    chk("halt_sticky", 32'(halted), 32'd1);
    chk("halt_no_traffic", 32'(m_axil_awvalid), 32'd0);

    #2 areset = 1'b1;
    @(negedge aclk);
    #2 areset = 1'b0;
    #1;
    chk("halt_exit_halted", 32'(halted), 32'd0);
    chk("halt_exit_ready", 32'(cmd_ready), 32'd1);

    // reset while waiting on a write response
    tv = vt[0];
    tv.b_lag = NEVER;
    configure(tv);
    @(negedge aclk);
    cmd_valid  = 1'b1;
    cmd_kidx   = 3'd3;
    cmd_ctrl   = 32'h11;
    cmd_row    = 32'h22;
    cmd_nnz    = 32'h33;
    cmd_verify = 1'b1;
    @(negedge aclk);
    cmd_valid = 1'b0;
    n = 0;
    while (!m_axil_bready && n < 100) begin
      @(negedge aclk);
      n++;
    end
    chk("mid_wr_resp_reached", 32'(m_axil_bready), 32'd1);
    #2 areset = 1'b1;
    #1;
    chk("async_reset_all_zero", 32'(|all_out), 32'd0);
    chk("async_reset_not_ready", 32'(cmd_ready), 32'd0);
    @(negedge aclk);
    #2 areset = 1'b0;
    #1;
    chk("post_reset_ready", 32'(cmd_ready), 32'd1);
    chk("post_reset_bready", 32'(m_axil_bready), 32'd0);

    run_vec(0);

    chk("no_aw_ar_overlap", 32'(overlap), 32'd0);
    chk("addr_data_stable", 32'(unstable), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
